// File: rtl/wptr_full_level_if.sv
// Write-side FIFO pointer/status bus: producer strobe and synchronised read
// pointer in, write address, Gray pointer and status flags out.
interface wptr_full_level_if #(
    parameter int ADDRSIZE = 4
);
    logic                winc;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic [ADDRSIZE:0]   afull_thresh;
    logic                wovf_clr;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE:0]   wlevel;
    logic                woverflow;

    modport master (
        output winc, wq2_rptr, afull_thresh, wovf_clr,
        input  waddr, wptr, wfull, walmost_full, wlevel, woverflow
    );

    modport slave (
        input  winc, wq2_rptr, afull_thresh, wovf_clr,
        output waddr, wptr, wfull, walmost_full, wlevel, woverflow
    );
endinterface

// File: rtl/wptr_full_level.sv
// Async FIFO write-side pointer generator: binary/Gray write pointer, full,
// almost-full, fill level and sticky overflow, all in the wclk domain.
module wptr_full_level #(
    parameter int ADDRSIZE = 4
) (
    input  logic              wclk,
    input  logic              wrst,
    wptr_full_level_if.slave  wif
);
    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wfull_q, wfull_d;
    logic          walmost_full_q, walmost_full_d;
    logic          woverflow_q, woverflow_d;

    logic          accept;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] full_cmp;

    // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i < PW; i++) begin
            rbin_s[i] = ^(wif.wq2_rptr >> i);
        end
    end

    assign full_cmp = {~wif.wq2_rptr[ADDRSIZE:ADDRSIZE-1], wif.wq2_rptr[ADDRSIZE-2:0]};

    always_comb begin
        accept         = wif.winc & ~wfull_q;
        wbin_d         = wbin_q + {{ADDRSIZE{1'b0}}, accept};
        wptr_d         = (wbin_d >> 1) ^ wbin_d;
        wfull_d        = (wptr_d == full_cmp);
        wlevel_d       = wbin_d - rbin_s;
        walmost_full_d = (wlevel_d >= wif.afull_thresh);
        // A new overflow event takes priority over a simultaneous clear.
        woverflow_d    = (wif.winc & wfull_q) | (woverflow_q & ~wif.wovf_clr);
    end

    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wlevel_q       <= '0;
            woverflow_q    <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wlevel_q       <= wlevel_d;
            woverflow_q    <= woverflow_d;
        end
    end

    assign wif.waddr        = wbin_q[ADDRSIZE-1:0];
    assign wif.wptr         = wptr_q;
    assign wif.wfull        = wfull_q;
    assign wif.walmost_full = walmost_full_q;
    assign wif.wlevel       = wlevel_q;
    assign wif.woverflow    = woverflow_q;

endmodule

// File: tb/tb_wptr_full_level.sv
// Bench for wptr_full_level: directed scenarios plus randomized traffic
// checked against an occupancy-count model of the FIFO write side.
module tb_wptr_full_level;
    localparam int A     = 4;
    localparam int DEPTH = 16;
    localparam int MOD   = 32;

    logic wclk = 1'b0;
    logic wrst = 1'b1;

    wptr_full_level_if #(.ADDRSIZE(A)) wif ();

    wptr_full_level #(.ADDRSIZE(A)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .wif  (wif)
    );

    always #5 wclk = ~wclk;

    int n_pass  = 0;
    int n_total = 0;

    // model: writes accepted (mod 32) and occupancy derived from read count
    int m_wbin = 0;
    int m_lvl  = 0;
    bit m_full = 0;
    bit m_af   = 0;
    bit m_ovf  = 0;

    function automatic logic [A:0] gray(input int b);
        logic [A:0] v;
        v = b[A:0];
        return v ^ (v >> 1);
    endfunction

    // Read count whose Gray code matches g, found by search.
    function automatic int bin_of_gray(input logic [A:0] g);
        for (int b = 0; b < MOD; b++) begin
            if (gray(b) == g) return b;
        end
        return 0;
    endfunction

    task automatic model_edge();
        bit acc;
        int nb, rb, lv;
        if (wrst) begin
            m_wbin = 0; m_lvl = 0; m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            acc    = wif.winc && !m_full;
            nb     = (m_wbin + int'(acc)) % MOD;
            rb     = bin_of_gray(wif.wq2_rptr);
            lv     = (nb - rb + MOD) % MOD;
            m_ovf  = (wif.winc && m_full) || (m_ovf && !wif.wovf_clr);
            m_full = (lv == DEPTH);
            m_af   = (lv >= int'(wif.afull_thresh));
            m_wbin = nb;
            m_lvl  = lv;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        wrst = 1'b1; wif.winc = 1'b1; wif.wq2_rptr = '0;
        wif.afull_thresh = 5'd12; wif.wovf_clr = 1'b0;
        tick(); tick();
        n_total++; if (wif.wptr !== 5'd0) $display("FAIL reset_wptr got %0h exp 0", wif.wptr); else n_pass++;
        n_total++; if (wif.waddr !== 4'd0) $display("FAIL reset_waddr got %0h exp 0", wif.waddr); else n_pass++;
        n_total++; if (wif.wfull !== 1'b0) $display("FAIL reset_wfull got %0b exp 0", wif.wfull); else n_pass++;
        n_total++; if (wif.wlevel !== 5'd0) $display("FAIL reset_wlevel got %0d exp 0", wif.wlevel); else n_pass++;
        n_total++; if (wif.woverflow !== 1'b0) $display("FAIL reset_wovf got %0b exp 0", wif.woverflow); else n_pass++;
    endtask

    task automatic test_fill();
        wrst = 1'b0; wif.winc = 1'b1; wif.afull_thresh = 5'd12;
        for (int i = 0; i < DEPTH; i++) begin
            n_total++; if (wif.waddr !== 4'(i)) $display("FAIL fill_waddr[%0d] got %0d exp %0d", i, wif.waddr, i); else n_pass++;
            tick();
            n_total++; if (wif.wlevel !== 5'(i + 1)) $display("FAIL fill_wlevel[%0d] got %0d exp %0d", i, wif.wlevel, i + 1); else n_pass++;
            n_total++; if (wif.walmost_full !== (i + 1 >= 12)) $display("FAIL fill_afull[%0d] got %0b exp %0b", i, wif.walmost_full, (i + 1 >= 12)); else n_pass++;
        end
        n_total++; if (wif.wfull !== 1'b1) $display("FAIL fill_wfull got %0b exp 1", wif.wfull); else n_pass++;
        n_total++; if (wif.wptr !== 5'b11000) $display("FAIL fill_wptr got %b exp 11000", wif.wptr); else n_pass++;
    endtask

    task automatic test_overflow();
        wif.winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (wif.wptr !== 5'b11000) $display("FAIL ovf_wptr[%0d] got %b exp 11000", i, wif.wptr); else n_pass++;
            n_total++; if (wif.wlevel !== 5'd16) $display("FAIL ovf_wlevel[%0d] got %0d exp 16", i, wif.wlevel); else n_pass++;
            n_total++; if (wif.woverflow !== 1'b1) $display("FAIL ovf_set[%0d] got %0b exp 1", i, wif.woverflow); else n_pass++;
        end
        wif.winc = 1'b0; wif.wovf_clr = 1'b1;
        tick();
        n_total++; if (wif.woverflow !== 1'b0) $display("FAIL ovf_clear got %0b exp 0", wif.woverflow); else n_pass++;
        wif.winc = 1'b1;
        tick();
        n_total++; if (wif.woverflow !== 1'b1) $display("FAIL ovf_set_wins got %0b exp 1", wif.woverflow); else n_pass++;
        wif.winc = 1'b0; wif.wovf_clr = 1'b0;
    endtask

    task automatic test_drain_refill();
        wif.wq2_rptr = 5'b11000; wif.winc = 1'b0;
        tick();
        n_total++; if (wif.wfull !== 1'b0) $display("FAIL drain_wfull got %0b exp 0", wif.wfull); else n_pass++;
        n_total++; if (wif.wlevel !== 5'd0) $display("FAIL drain_wlevel got %0d exp 0", wif.wlevel); else n_pass++;
        wif.winc = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            if (i == DEPTH - 2) begin
                n_total++; if (wif.wptr !== 5'b10000) $display("FAIL refill_wptr31 got %b exp 10000", wif.wptr); else n_pass++;
                n_total++; if (wif.wfull !== 1'b0) $display("FAIL refill_notfull got %0b exp 0", wif.wfull); else n_pass++;
            end
        end
        n_total++; if (wif.wptr !== 5'b00000) $display("FAIL refill_wptr0 got %b exp 00000", wif.wptr); else n_pass++;
        n_total++; if (wif.wfull !== 1'b1) $display("FAIL refill_wfull got %0b exp 1", wif.wfull); else n_pass++;
        n_total++; if (wif.wlevel !== 5'd16) $display("FAIL refill_wlevel got %0d exp 16", wif.wlevel); else n_pass++;
        wif.winc = 1'b0;
    endtask

    task automatic test_thresholds();
        wif.afull_thresh = 5'd17;
        tick();
        n_total++; if (wif.walmost_full !== 1'b0) $display("FAIL thresh17_afull got %0b exp 0", wif.walmost_full); else n_pass++;
        n_total++; if (wif.wfull !== 1'b1) $display("FAIL thresh17_wfull got %0b exp 1", wif.wfull); else n_pass++;
        wif.wq2_rptr = 5'b00000; wif.afull_thresh = 5'd0;
        tick();
        n_total++; if (wif.wlevel !== 5'd0) $display("FAIL thresh0_wlevel got %0d exp 0", wif.wlevel); else n_pass++;
        n_total++; if (wif.walmost_full !== 1'b1) $display("FAIL thresh0_afull got %0b exp 1", wif.walmost_full); else n_pass++;
        wif.afull_thresh = 5'd12;
    endtask

    task automatic test_reset_while_full();
        wif.winc = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) tick();
        n_total++; if (wif.wfull !== 1'b1 || wif.woverflow !== 1'b1)
            $display("FAIL rwf_setup got full=%0b ovf=%0b exp 1/1", wif.wfull, wif.woverflow); else n_pass++;
        wrst = 1'b1;
        tick();
        n_total++; if ({wif.wptr, wif.waddr, wif.wfull, wif.walmost_full, wif.wlevel, wif.woverflow} !== '0)
            $display("FAIL rwf_reset got wptr=%b waddr=%0d full=%0b af=%0b lvl=%0d ovf=%0b exp all 0",
                     wif.wptr, wif.waddr, wif.wfull, wif.walmost_full, wif.wlevel, wif.woverflow); else n_pass++;
        wrst = 1'b0;
        tick();
        n_total++; if (wif.waddr !== 4'd1) $display("FAIL rwf_waddr got %0d exp 1", wif.waddr); else n_pass++;
        n_total++; if (wif.wptr !== 5'b00001) $display("FAIL rwf_wptr got %b exp 00001", wif.wptr); else n_pass++;
        wif.winc = 1'b0;
    endtask

    task automatic test_random();
        int rb;
        rb = bin_of_gray(wif.wq2_rptr);
        for (int c = 0; c < 400; c++) begin
            wif.winc         = 1'($urandom_range(0, 99) < 60);
            wif.wovf_clr     = 1'($urandom_range(0, 7) == 0);
            wif.afull_thresh = 5'($urandom_range(0, 17));
            wrst             = 1'($urandom_range(0, 149) == 0);
            if (wrst) rb = 0;
            else if (((m_wbin - rb + MOD) % MOD) > 0 && $urandom_range(0, 2) == 0) rb = (rb + 1) % MOD;
            wif.wq2_rptr = gray(rb);
            tick();
            n_total++; if (wif.waddr !== 4'(m_wbin % DEPTH)) $display("FAIL rnd_waddr c=%0d got %0d exp %0d", c, wif.waddr, m_wbin % DEPTH); else n_pass++;
            n_total++; if (wif.wptr !== gray(m_wbin)) $display("FAIL rnd_wptr c=%0d got %b exp %b", c, wif.wptr, gray(m_wbin)); else n_pass++;
            n_total++; if (wif.wfull !== m_full) $display("FAIL rnd_wfull c=%0d got %0b exp %0b", c, wif.wfull, m_full); else n_pass++;
            n_total++; if (wif.walmost_full !== m_af) $display("FAIL rnd_afull c=%0d got %0b exp %0b", c, wif.walmost_full, m_af); else n_pass++;
            n_total++; if (wif.wlevel !== 5'(m_lvl)) $display("FAIL rnd_wlevel c=%0d got %0d exp %0d", c, wif.wlevel, m_lvl); else n_pass++;
            n_total++; if (wif.woverflow !== m_ovf) $display("FAIL rnd_wovf c=%0d got %0b exp %0b", c, wif.woverflow, m_ovf); else n_pass++;
        end
        wrst = 1'b0;
    endtask

    initial begin
        wif.winc = 1'b0; wif.wq2_rptr = '0; wif.afull_thresh = '0; wif.wovf_clr = 1'b0;
        #1;
        test_reset();
        test_fill();
        test_overflow();
        test_drain_refill();
        test_thresholds();
        test_reset_while_full();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
